// File: rtl/traffic_pkg.sv
// Shared lamp-state encodings, fault codes and approach indices for the
// traffic conflict monitor and its per-approach checkers.
package traffic_pkg;

    typedef enum logic [1:0] {
        RED    = 2'b00,
        YELLOW = 2'b01,
        GREEN  = 2'b10,
        ERR    = 2'b11
    } lamp_t;

    // Fault codes; a lower code has higher priority.
    localparam logic [2:0] FC_NONE        = 3'd0;
    localparam logic [2:0] FC_INVALID     = 3'd1;
    localparam logic [2:0] FC_CONFLICT    = 3'd2;
    localparam logic [2:0] FC_TRANSITION  = 3'd3;
    localparam logic [2:0] FC_YELLOW_TIME = 3'd4;
    localparam logic [2:0] FC_SHORT_GREEN = 3'd5;
    localparam logic [2:0] FC_MAX_GREEN   = 3'd6;
    localparam logic [2:0] FC_CLEARANCE   = 3'd7;

    // Approach indices, also reported on fault_src.
    localparam int APP_HWY  = 0;
    localparam int APP_SIDE = 1;
    localparam int APP_PED  = 2;
    localparam int NUM_APP  = 3;

    // Bit positions in the per-approach violation vector.
    localparam int VB_INVALID     = 0;
    localparam int VB_TRANSITION  = 1;
    localparam int VB_YELLOW      = 2;
    localparam int VB_SHORT_GREEN = 3;
    localparam int VB_MAX_GREEN   = 4;
    localparam int VB_WIDTH       = 5;

endpackage

// File: rtl/approach_checker.sv
// Per-approach checker: remembers the previous lamp state and how long it has
// been held, and flags encoding, transition-order and phase-duration errors.
module approach_checker
    import traffic_pkg::*;
#(
    parameter int YELLOW_TIME = 3,
    parameter int MIN_GREEN   = 6,
    parameter int MAX_GREEN   = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          state,
    output logic                is_nonred,
    output logic                became_red,
    output logic                started_green,
    output logic [VB_WIDTH-1:0] viol
);

    localparam logic [3:0] YEL_LIM = 4'(YELLOW_TIME);
    localparam logic [3:0] GRN_MIN = 4'(MIN_GREEN);
    localparam logic [3:0] GRN_MAX = 4'(MAX_GREEN);

    lamp_t      cur;
    lamp_t      prev_state;
    logic [3:0] run_cnt;

    assign cur = lamp_t'(state);

    // Track the last sampled state and a saturating count of how long it has held.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_state <= RED;
            run_cnt    <= 4'd15;
        end else begin
            prev_state <= cur;
            if (cur != prev_state) begin
                run_cnt <= 4'd1;
            end else if (run_cnt != 4'd15) begin
                run_cnt <= run_cnt + 4'd1;
            end
        end
    end

    assign is_nonred     = (cur != RED);
    assign became_red    = (prev_state == YELLOW) && (cur == RED);
    assign started_green = (prev_state == RED) && (cur == GREEN);

    assign viol[VB_INVALID]    = (cur == ERR);
    assign viol[VB_TRANSITION] = ((prev_state == GREEN)  && (cur == RED))    ||
                                 ((prev_state == YELLOW) && (cur == GREEN))  ||
                                 ((prev_state == RED)    && (cur == YELLOW));
    assign viol[VB_YELLOW]     = (prev_state == YELLOW) &&
                                 (((cur == RED) && (run_cnt < YEL_LIM)) ||
                                  ((cur == YELLOW) && (run_cnt >= YEL_LIM)));
    assign viol[VB_SHORT_GREEN] = (prev_state == GREEN) && (cur == YELLOW) &&
                                  (run_cnt < GRN_MIN);
    assign viol[VB_MAX_GREEN]   = (MAX_GREEN != 0) && (prev_state == GREEN) &&
                                  (cur == GREEN) && (run_cnt >= GRN_MAX);

endmodule

// File: rtl/traffic_conflict_monitor.sv
// Safety monitor between the lamp timers and the LED converters: passes the
// lamp states through one register stage, and on the first violation latches
// a fault code and forces flashing red until a clean clear request.
module traffic_conflict_monitor
    import traffic_pkg::*;
#(
    parameter int YELLOW_TIME    = 3,
    parameter int MIN_GREEN      = 6,
    parameter int MAX_SIDE_GREEN = 15,
    parameter int ALL_RED_MIN    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] hwy_state,
    input  logic [1:0] side_state,
    input  logic [1:0] ped_state,
    input  logic       fault_clr,
    output logic [1:0] hwy_out,
    output logic [1:0] side_out,
    output logic [1:0] ped_out,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic [1:0] fault_src,
    output logic       lamp_en
);

    localparam logic [3:0] ALL_RED_LIM = 4'(ALL_RED_MIN);

    logic [1:0]          st [NUM_APP];
    logic [NUM_APP-1:0]  is_nonred;
    logic [NUM_APP-1:0]  became_red;
    logic [NUM_APP-1:0]  started_green;
    logic [VB_WIDTH-1:0] viol [NUM_APP];
    logic [3:0]          all_red_cnt;
    logic                conflict;
    logic                clearance_short;
    logic                inputs_all_red;
    logic [NUM_APP-1:0]  hit [1:7];
    logic                new_viol;
    logic [2:0]          new_code;
    logic [1:0]          new_src;

    assign st[APP_HWY]  = hwy_state;
    assign st[APP_SIDE] = side_state;
    assign st[APP_PED]  = ped_state;

    for (genvar g = 0; g < NUM_APP; g++) begin : g_app
        approach_checker #(
            .YELLOW_TIME (YELLOW_TIME),
            .MIN_GREEN   (MIN_GREEN),
            .MAX_GREEN   ((g == APP_SIDE) ? MAX_SIDE_GREEN : 0)
        ) u_checker (
            .clk           (clk),
            .reset         (reset),
            .state         (st[g]),
            .is_nonred     (is_nonred[g]),
            .became_red    (became_red[g]),
            .started_green (started_green[g]),
            .viol          (viol[g])
        );
    end

    // Count all-red samples since the last yellow-to-red change, saturating.
    always_ff @(posedge clk) begin
        if (reset) begin
            all_red_cnt <= 4'd15;
        end else if (|became_red) begin
            all_red_cnt <= 4'd0;
        end else if ((is_nonred == '0) && (all_red_cnt != 4'd15)) begin
            all_red_cnt <= all_red_cnt + 4'd1;
        end
    end

    assign conflict        = (is_nonred[0] & is_nonred[1]) |
                             (is_nonred[0] & is_nonred[2]) |
                             (is_nonred[1] & is_nonred[2]);
    assign clearance_short = (all_red_cnt < ALL_RED_LIM);
    assign inputs_all_red  = ({hwy_state, side_state, ped_state} == 6'b0);

    // Gather per-code hits and pick the lowest code, then the lowest approach.
    always_comb begin
        for (int c = 1; c <= 7; c++) begin
            hit[c] = '0;
        end
        for (int a = 0; a < NUM_APP; a++) begin
            hit[FC_INVALID][a]     = viol[a][VB_INVALID];
            hit[FC_CONFLICT][a]    = conflict & is_nonred[a];
            hit[FC_TRANSITION][a]  = viol[a][VB_TRANSITION];
            hit[FC_YELLOW_TIME][a] = viol[a][VB_YELLOW];
            hit[FC_SHORT_GREEN][a] = viol[a][VB_SHORT_GREEN];
            hit[FC_MAX_GREEN][a]   = viol[a][VB_MAX_GREEN];
            hit[FC_CLEARANCE][a]   = clearance_short & started_green[a];
        end
        new_viol = 1'b0;
        new_code = FC_NONE;
        new_src  = 2'd0;
        for (int c = 7; c >= 1; c--) begin
            for (int a = NUM_APP - 1; a >= 0; a--) begin
                if (hit[c][a]) begin
                    new_viol = 1'b1;
                    new_code = 3'(c);
                    new_src  = 2'(a);
                end
            end
        end
    end

    // Fault latch and output stage: pass-through when healthy, flashing red when faulted.
    always_ff @(posedge clk) begin
        if (reset) begin
            hwy_out    <= RED;
            side_out   <= RED;
            ped_out    <= RED;
            fault      <= 1'b0;
            fault_code <= FC_NONE;
            fault_src  <= 2'd0;
            lamp_en    <= 1'b1;
        end else if (!fault) begin
            if (new_viol) begin
                hwy_out    <= RED;
                side_out   <= RED;
                ped_out    <= RED;
                fault      <= 1'b1;
                fault_code <= new_code;
                fault_src  <= new_src;
                lamp_en    <= 1'b0;
            end else begin
                hwy_out  <= hwy_state;
                side_out <= side_state;
                ped_out  <= ped_state;
                lamp_en  <= 1'b1;
            end
        end else begin
            hwy_out  <= RED;
            side_out <= RED;
            ped_out  <= RED;
            if (fault_clr && inputs_all_red && !new_viol) begin
                fault      <= 1'b0;
                fault_code <= FC_NONE;
                fault_src  <= 2'd0;
                lamp_en    <= 1'b1;
            end else begin
                lamp_en <= ~lamp_en;
            end
        end
    end

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// Directed bench for traffic_conflict_monitor: legal phase cycle, each fault
// code, fault flashing, clear handling and reset while faulted.
module tb_traffic_conflict_monitor;

    localparam logic [1:0] R = 2'b00;
    localparam logic [1:0] Y = 2'b01;
    localparam logic [1:0] G = 2'b10;
    localparam logic [1:0] E = 2'b11;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] hwy_state;
    logic [1:0] side_state;
    logic [1:0] ped_state;
    logic       fault_clr;
    logic [1:0] hwy_out;
    logic [1:0] side_out;
    logic [1:0] ped_out;
    logic       fault;
    logic [2:0] fault_code;
    logic [1:0] fault_src;
    logic       lamp_en;

    int tests_run    = 0;
    int tests_failed = 0;

    traffic_conflict_monitor dut (
        .clk        (clk),
        .reset      (reset),
        .hwy_state  (hwy_state),
        .side_state (side_state),
        .ped_state  (ped_state),
        .fault_clr  (fault_clr),
        .hwy_out    (hwy_out),
        .side_out   (side_out),
        .ped_out    (ped_out),
        .fault      (fault),
        .fault_code (fault_code),
        .fault_src  (fault_src),
        .lamp_en    (lamp_en)
    );

    // Free-running slow clock stand-in.
    always #5 clk = ~clk;

    task automatic apply_stimulus(input logic [1:0] h, input logic [1:0] s,
                                  input logic [1:0] p, input logic clr);
        hwy_state  = h;
        side_state = s;
        ped_state  = p;
        fault_clr  = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag,
                                input logic [1:0] eh, input logic [1:0] es,
                                input logic [1:0] ep, input logic ef,
                                input logic [2:0] ec, input logic [1:0] esrc,
                                input logic el);
        logic [12:0] obs;
        logic [12:0] exp_v;
        obs   = {hwy_out, side_out, ped_out, fault, fault_code, fault_src, lamp_en};
        exp_v = {eh, es, ep, ef, ec, esrc, el};
        tests_run++;
        assert (obs === exp_v) else begin
            tests_failed++;
            $error("[TB] FAIL %s observed={out=%b_%b_%b fault=%b code=%0d src=%0d lamp=%b} expected={out=%b_%b_%b fault=%b code=%0d src=%0d lamp=%b}",
                   tag, hwy_out, side_out, ped_out, fault, fault_code, fault_src, lamp_en,
                   eh, es, ep, ef, ec, esrc, el);
        end
    endtask

    // Healthy sample: outputs mirror the inputs one edge later.
    task automatic pass_step(input string tag, input logic [1:0] h,
                             input logic [1:0] s, input logic [1:0] p);
        apply_stimulus(h, s, p, 1'b0);
        check_output(tag, h, s, p, 1'b0, 3'd0, 2'd0, 1'b1);
    endtask

    // Faulted sample: outputs forced red with the latched code and given lamp phase.
    task automatic fault_step(input string tag, input logic [1:0] h,
                              input logic [1:0] s, input logic [1:0] p,
                              input logic clr, input logic [2:0] code,
                              input logic [1:0] src, input logic lamp);
        apply_stimulus(h, s, p, clr);
        check_output(tag, R, R, R, 1'b1, code, src, lamp);
    endtask

    // Clean clear request with all approaches red.
    task automatic clear_step(input string tag);
        apply_stimulus(R, R, R, 1'b1);
        check_output(tag, R, R, R, 1'b0, 3'd0, 2'd0, 1'b1);
    endtask

    initial begin
        reset      = 1'b1;
        hwy_state  = R;
        side_state = R;
        ped_state  = R;
        fault_clr  = 1'b0;

        apply_stimulus(G, G, G, 1'b0);
        check_output("reset_state", R, R, R, 1'b0, 3'd0, 2'd0, 1'b1);
        apply_stimulus(R, R, R, 1'b0);
        reset = 1'b0;

        // Legal full cycle through all three approaches.
        for (int i = 0; i < 6; i++)  pass_step("legal_hwy_green", G, R, R);
        for (int i = 0; i < 3; i++)  pass_step("legal_hwy_yellow", Y, R, R);
        pass_step("legal_hwy_red", R, R, R);
        pass_step("legal_allred_1", R, R, R);
        for (int i = 0; i < 15; i++) pass_step("legal_side_green", R, G, R);
        for (int i = 0; i < 3; i++)  pass_step("legal_side_yellow", R, Y, R);
        pass_step("legal_side_red", R, R, R);
        pass_step("legal_allred_2", R, R, R);
        for (int i = 0; i < 6; i++)  pass_step("legal_ped_green", R, R, G);
        for (int i = 0; i < 3; i++)  pass_step("legal_ped_yellow", R, R, Y);
        pass_step("legal_ped_red", R, R, R);

        // Two greens at once, flashing, blocked clear, then a clean clear.
        pass_step("pre_conflict_allred", R, R, R);
        fault_step("conflict_entry", G, G, R, 1'b0, 3'd2, 2'd0, 1'b0);
        fault_step("conflict_flash_1", G, G, R, 1'b0, 3'd2, 2'd0, 1'b1);
        fault_step("conflict_flash_2", G, G, R, 1'b0, 3'd2, 2'd0, 1'b0);
        fault_step("conflict_flash_3", G, G, R, 1'b0, 3'd2, 2'd0, 1'b1);
        fault_step("clr_with_new_violation", R, R, R, 1'b1, 3'd2, 2'd0, 1'b0);
        clear_step("clear_after_conflict");

        // Green straight to red.
        for (int i = 0; i < 6; i++) pass_step("g2r_hwy_green", G, R, R);
        fault_step("g2r_illegal", R, R, R, 1'b0, 3'd3, 2'd0, 1'b0);
        clear_step("clear_after_g2r");

        // Pedestrian yellow held one cycle too long.
        for (int i = 0; i < 6; i++) pass_step("longy_ped_green", R, R, G);
        for (int i = 0; i < 3; i++) pass_step("longy_ped_yellow", R, R, Y);
        fault_step("longy_4th_yellow", R, R, Y, 1'b0, 3'd4, 2'd2, 1'b0);
        clear_step("clear_after_longy");
        pass_step("longy_allred", R, R, R);

        // Side green cut short.
        for (int i = 0; i < 4; i++) pass_step("shortg_side_green", R, G, R);
        fault_step("shortg_entry", R, Y, R, 1'b0, 3'd5, 2'd1, 1'b0);
        fault_step("shortg_flash_1", R, Y, R, 1'b0, 3'd5, 2'd1, 1'b1);
        fault_step("shortg_flash_2", R, Y, R, 1'b0, 3'd5, 2'd1, 1'b0);
        clear_step("clear_after_shortg");
        pass_step("shortg_allred", R, R, R);

        // Side green held past its maximum.
        for (int i = 0; i < 15; i++) pass_step("maxg_side_green", R, G, R);
        fault_step("maxg_16th_green", R, G, R, 1'b0, 3'd6, 2'd1, 1'b0);
        fault_step("maxg_yellow_1", R, Y, R, 1'b0, 3'd6, 2'd1, 1'b1);
        fault_step("maxg_yellow_2", R, Y, R, 1'b0, 3'd6, 2'd1, 1'b0);
        fault_step("maxg_yellow_3", R, Y, R, 1'b0, 3'd6, 2'd1, 1'b1);
        clear_step("clear_after_maxg");
        pass_step("maxg_allred", R, R, R);

        // Side goes green with no all-red gap after highway clears.
        for (int i = 0; i < 6; i++) pass_step("clr_hwy_green", G, R, R);
        for (int i = 0; i < 3; i++) pass_step("clr_hwy_yellow", Y, R, R);
        pass_step("clr_hwy_red", R, R, R);
        fault_step("clearance_entry", R, G, R, 1'b0, 3'd7, 2'd1, 1'b0);
        fault_step("invalid_while_faulted", R, E, R, 1'b0, 3'd7, 2'd1, 1'b1);
        fault_step("clr_ignored_ped_green", R, R, G, 1'b1, 3'd7, 2'd1, 1'b0);

        // Reset while faulted.
        reset = 1'b1;
        apply_stimulus(R, R, G, 1'b0);
        check_output("reset_mid_fault", R, R, R, 1'b0, 3'd0, 2'd0, 1'b1);
        reset = 1'b0;

        // Clear request with no fault latched, then an invalid encoding.
        pass_step("clr_without_fault", R, R, R);
        apply_stimulus(R, R, R, 1'b1);
        check_output("clr_no_fault_noop", R, R, R, 1'b0, 3'd0, 2'd0, 1'b1);
        fault_step("invalid_hwy", E, R, R, 1'b0, 3'd1, 2'd0, 1'b0);
        clear_step("clear_after_invalid");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
